// File: rtl/limb_add_seq_pkg.sv
// Shared constants and FSM encoding for the base-1000 limb add/sub sequencer.
`timescale 1ns/1ps
package limb_add_seq_pkg;

    localparam int LIMB_W    = 10;
    localparam int RADIX     = 1000;
    localparam int DIGIT_MAX = 999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        FIN   = 2'd3
    } state_e;

    // The subtrahend in 999-complement form; subtraction becomes an add with initial carry 1.
    function automatic logic [LIMB_W-1:0] nineComplement(input logic [LIMB_W-1:0] d);
        return LIMB_W'(DIGIT_MAX) - d;
    endfunction

endpackage

// File: rtl/limb_add_seq_add10bitD.sv
// Single base-1000 limb adder: q = (a + b + cin) mod 1000, cout = (a + b + cin) >= 1000.
`timescale 1ns/1ps
module limb_add_seq_add10bitD
    import limb_add_seq_pkg::*;
(
    input  logic [LIMB_W-1:0] a_i,
    input  logic [LIMB_W-1:0] b_i,
    input  logic              cin_i,
    output logic [LIMB_W-1:0] q_o,
    output logic              cout_o
);

    logic [11:0] sum;
    logic        wrap;

    // Inputs above 999 still produce some 10-bit value; the caller flags those separately.
    always_comb begin
        sum    = 12'(a_i) + 12'(b_i) + 12'(cin_i);
        wrap   = (sum >= 12'(RADIX));
        cout_o = wrap;
        q_o    = wrap ? LIMB_W'(sum - 12'(RADIX)) : LIMB_W'(sum);
    end

endmodule

// File: rtl/limb_add_seq.sv
// Walks two N_LIMBS-limb decimal operands through one limb adder, least significant limb first,
// writing each result limb to the result RAM and reporting final carry/borrow and bad digits.
`timescale 1ns/1ps
module limb_add_seq
    import limb_add_seq_pkg::*;
#(
    parameter int N_LIMBS = 100,
    parameter int ADDR_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_sub,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [LIMB_W-1:0] a_rdata,
    input  logic [LIMB_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] q_addr,
    output logic [LIMB_W-1:0] q_wdata,
    output logic              q_we,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              digit_err
);

    state_e            state_q, state_d;
    logic              opSub_q, opSub_d;
    logic              carry_q, carry_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
    logic [ADDR_W-1:0] qAddr_q, qAddr_d;
    logic [LIMB_W-1:0] qWdata_q, qWdata_d;
    logic              qWe_q, qWe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              digitErr_q, digitErr_d;

    logic [LIMB_W-1:0] bOperand;
    logic [LIMB_W-1:0] limbSum;
    logic              limbCarry;
    logic              lastLimb;

    assign bOperand = opSub_q ? nineComplement(b_rdata) : b_rdata;
    assign lastLimb = (idx_q == ADDR_W'(N_LIMBS - 1));

    limb_add_seq_add10bitD add10bitD_u (
        .a_i    (a_rdata),
        .b_i    (bOperand),
        .cin_i  (carry_q),
        .q_o    (limbSum),
        .cout_o (limbCarry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = EXEC;
            EXEC:    state_d = lastLimb ? FIN : FETCH;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rd_addr is loaded on entry to FETCH so the RAM samples it at the FETCH->EXEC edge.
    always_comb begin
        opSub_d    = opSub_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        rdAddr_d   = rdAddr_q;
        qAddr_d    = qAddr_q;
        qWdata_d   = qWdata_q;
        qWe_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        digitErr_d = digitErr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opSub_d    = op_sub;
                    carry_d    = op_sub;
                    idx_d      = '0;
                    rdAddr_d   = '0;
                    overflow_d = 1'b0;
                    digitErr_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            FETCH: begin
                rdAddr_d = idx_q;
            end
            EXEC: begin
                qAddr_d    = idx_q;
                qWdata_d   = limbSum;
                qWe_d      = 1'b1;
                carry_d    = limbCarry;
                digitErr_d = digitErr_q | (a_rdata > LIMB_W'(DIGIT_MAX))
                                        | (b_rdata > LIMB_W'(DIGIT_MAX));
                if (!lastLimb) begin
                    idx_d    = idx_q + ADDR_W'(1);
                    rdAddr_d = idx_q + ADDR_W'(1);
                end
            end
            FIN: begin
                overflow_d = opSub_q ? ~carry_q : carry_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opSub_q    <= 1'b0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            rdAddr_q   <= '0;
            qAddr_q    <= '0;
            qWdata_q   <= '0;
            qWe_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            digitErr_q <= 1'b0;
        end else begin
            opSub_q    <= opSub_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            rdAddr_q   <= rdAddr_d;
            qAddr_q    <= qAddr_d;
            qWdata_q   <= qWdata_d;
            qWe_q      <= qWe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            digitErr_q <= digitErr_d;
        end
    end

    assign rd_addr   = rdAddr_q;
    assign q_addr    = qAddr_q;
    assign q_wdata   = qWdata_q;
    assign q_we      = qWe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign digit_err = digitErr_q;

endmodule
